// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with data-memory handshake, stall, branch redirect and MEM/WB register (optional MEM_TIMEOUT_EN)
`timescale 1ns/1ps
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writedata,
    input  logic [4:0]  writeReg,
    input  logic        BranchTaken,
    input  logic [7:0]  BranchTarget,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        PCSrc,
    output logic [7:0]  PCBranchTarget,
    output logic        RegWriteOut,
    output logic        MemtoRegOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  writeRegOut,
    output logic        mem_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t state, next_state;
    logic   memop;
    logic   is_load;
    logic   timeout_hit;

    // A read with the write bit also set is a store, so it never returns data.
    assign memop   = MemRead | MemWrite;
    assign is_load = MemRead & ~MemWrite;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] count;

    assign timeout_hit = (state == WAIT) & (count == 4'd15) & ~dmem_ack;

    // Count unacknowledged WAIT cycles; cleared whenever the access ends or is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if ((state == WAIT) && !dmem_ack && !timeout_hit) begin
            count <= count + 4'd1;
        end else begin
            count <= 4'd0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if (timeout_hit) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    assign dmem_req       = ~reset & memop;
    assign dmem_we        = MemWrite;
    assign dmem_addr      = ALUResult[9:2];
    assign dmem_wdata     = writedata;
    assign stall          = ~reset & memop & ~dmem_ack & ~timeout_hit;
    assign PCSrc          = BranchTaken & ~stall;
    assign PCBranchTarget = BranchTarget;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Enter WAIT on an unanswered request; leave on ack, timeout or a vanished request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (memop && !dmem_ack) next_state = WAIT;
            WAIT: if (!memop || dmem_ack || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // MEM/WB register: real instruction when not stalled, bubble otherwise.
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            ReadDataOut  <= 32'h0;
            ALUResultOut <= 32'h0;
            writeRegOut  <= 5'd0;
        end else begin
            RegWriteOut  <= RegWrite;
            MemtoRegOut  <= MemtoReg;
            ReadDataOut  <= (is_load && !timeout_hit) ? dmem_rdata : 32'h0;
            ALUResultOut <= ALUResult;
            writeRegOut  <= writeReg;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with a transaction-level reference model
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, MemtoReg, MemWrite, MemRead;
    logic [31:0] ALUResult, writedata;
    logic [4:0]  writeReg;
    logic        BranchTaken;
    logic [7:0]  BranchTarget;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, PCSrc;
    logic [7:0]  PCBranchTarget;
    logic        RegWriteOut, MemtoRegOut;
    logic [31:0] ReadDataOut, ALUResultOut;
    logic [4:0]  writeRegOut;
    logic        mem_err;

    int passed = 0;
    int total  = 0;
    bit exp_err = 1'b0;

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
        .ALUResult(ALUResult), .writedata(writedata), .writeReg(writeReg),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .PCSrc(PCSrc), .PCBranchTarget(PCBranchTarget),
        .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .ReadDataOut(ReadDataOut),
        .ALUResultOut(ALUResultOut), .writeRegOut(writeRegOut), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic idle_inputs();
        RegWrite = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0;
        ALUResult = 0; writedata = 0; writeReg = 0;
        BranchTaken = 0; BranchTarget = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // One instruction held in EX/MEM until the model says it completes.
    // The memory answers 'lat' cycles after the first request (0 = same cycle).
    task automatic do_txn(input logic rd, input logic wr, input logic rw, input logic m2r,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                          input int lat, input logic br, input logic [7:0] tgt,
                          input logic [31:0] rdata, input string name);
        bit memop;
        bit to;
        bit exp_stall;
        int rel;
        logic [10:0] exp_c, got_c;
        logic [40:0] exp_m, got_m;
        logic [102:0] exp_w, got_w;
        memop = rd | wr;
        rel = memop ? lat : 0;
        to = 0;
`ifdef MEM_TIMEOUT_EN
        if (memop && lat > 16) begin
            rel = 16;
            to = 1;
        end
`endif
        for (int c = 0; c <= rel; c++) begin
            @(negedge clk);
            MemRead = rd; MemWrite = wr; RegWrite = rw; MemtoReg = m2r;
            ALUResult = alu; writedata = wd; writeReg = wreg;
            BranchTaken = br; BranchTarget = tgt; dmem_rdata = rdata;
            dmem_ack = memop ? (c == lat) : 1'($urandom_range(0, 1));
            #1;
            exp_stall = memop && (c < rel);
            exp_c = {exp_stall, memop, br && !exp_stall, tgt};
            got_c = {stall, dmem_req, PCSrc, PCBranchTarget};
            total++;
            if (got_c !== exp_c) $display("FAIL %s comb c=%0d: got {stall,req,pcsrc,tgt}=%h want %h", name, c, got_c, exp_c);
            else passed++;
            if (memop) begin
                exp_m = {wr, alu[9:2], wd};
                got_m = {dmem_we, dmem_addr, dmem_wdata};
                total++;
                if (got_m !== exp_m) $display("FAIL %s dmem c=%0d: got {we,addr,wdata}=%h want %h", name, c, got_m, exp_m);
                else passed++;
            end
            @(posedge clk);
            #1;
            if (exp_stall) exp_w = '0;
            else exp_w = {rw, m2r, (rd && !wr && !to) ? rdata : 32'h0, alu, wreg};
            if (to && c == rel) exp_err = 1'b1;
            got_w = {RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut};
            total++;
            if (got_w !== exp_w) $display("FAIL %s memwb c=%0d: got %h want %h", name, c, got_w, exp_w);
            else passed++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1; MemRead = 1; ALUResult = 32'h40; BranchTaken = 0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        total++;
        if ({dmem_req, stall} !== 2'b00) $display("FAIL reset_req_stall: got %b want 00", {dmem_req, stall});
        else passed++;
        total++;
        if ({RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut, mem_err} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut, mem_err});
        else passed++;
        exp_err = 1'b0;
        idle_inputs();
        reset = 0;
    endtask

    task automatic test_directed();
        do_txn(0, 0, 1, 0, 32'h1234, 32'h0, 5'd5, 0, 0, 8'h00, 32'hDEAD_BEEF, "alu_op");
        do_txn(1, 0, 1, 1, 32'h40, 32'h0, 5'd7, 0, 0, 8'h00, 32'hCAFE_F00D, "load_same_cycle");
        do_txn(0, 1, 0, 0, 32'h88, 32'h5555_AAAA, 5'd0, 3, 0, 8'h00, 32'h0, "store_3wait");
        do_txn(1, 0, 1, 1, 32'h104, 32'h0, 5'd9, 2, 1, 8'h2A, 32'h1357_9BDF, "branch_under_stall");
        do_txn(1, 1, 0, 0, 32'h3FF, 32'hFACE_0001, 5'd3, 1, 0, 8'h00, 32'h7777_7777, "read_write_both");
    endtask

    task automatic test_ack_outside_memop();
        for (int i = 0; i < 4; i++)
            do_txn(0, 0, 1, 0, $urandom, 32'h0, 5'($urandom), 0, 1'($urandom), 8'($urandom), $urandom, "stray_ack");
        do_txn(1, 0, 1, 1, 32'h20, 32'h0, 5'd1, 2, 0, 8'h00, 32'h0BAD_CAFE, "load_after_stray_ack");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom), $urandom_range(0, 5),
                   1'($urandom), 8'($urandom), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        idle_inputs();
        MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h80; writeReg = 5'd4;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        total++;
        if ({dmem_req, stall} !== 2'b00) $display("FAIL midwait_reset_req_stall: got %b want 00", {dmem_req, stall});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut, mem_err} !== '0)
            $display("FAIL midwait_reset_outputs: got %h want 0", {RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut, mem_err});
        else passed++;
        exp_err = 1'b0;
        @(negedge clk);
        reset = 0;
        idle_inputs();
        do_txn(1, 0, 1, 1, 32'hC0, 32'h0, 5'd6, 1, 0, 8'h00, 32'h2468_ACE0, "load_after_reset");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_txn(1, 0, 1, 1, 32'h44, 32'h0, 5'd2, 100, 1, 8'h11, 32'hFFFF_FFFF, "timeout_load");
        do_txn(0, 0, 1, 0, 32'h99, 32'h0, 5'd8, 0, 0, 8'h00, 32'h0, "after_timeout");
        do_txn(0, 1, 0, 0, 32'h48, 32'h1, 5'd0, 16, 0, 8'h00, 32'h0, "ack_at_count15");
    endtask
`endif

    task automatic test_mem_err();
        @(negedge clk); #1;
        total++;
        if (mem_err !== exp_err) $display("FAIL mem_err: got %b want %b", mem_err, exp_err);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_directed();
        test_ack_outside_memop();
        test_random();
        test_mem_err();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
        test_mem_err();
`endif
        test_reset_mid_wait();
        test_mem_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL: RegWrite, MemtoReg, MemWrite, MemRead  input  1 each  control bits from the EX/MEM register.
REQ-004 SHALL: ALUResult  input  32  byte address for memory ops, or the result for non-memory ops.
REQ-005 SHALL: writedata  input  32  store data; writeReg  input  5  destination register.
REQ-006 SHALL: BranchTaken  input  1; BranchTarget  input  8  resolved branch from the EX/MEM register.
REQ-007 SHALL: dmem_req  output  1; dmem_we  output  1; dmem_addr  output  8 (word address); dmem_wdata  output  32.
REQ-008 SHALL: dmem_ack  input  1; dmem_rdata  input  32  memory completion and read data.
REQ-009 SHALL: stall  output  1  holds the PC, IF/ID, ID/EX and EX/MEM registers while high.
REQ-010 SHALL: PCSrc  output  1; PCBranchTarget  output  8  branch redirect to IF.
REQ-011 SHALL: MEM/WB outputs RegWriteOut 1, MemtoRegOut 1, ReadDataOut 32, ALUResultOut 32, writeRegOut 5.
REQ-012 SHALL: mem_err  output  1  sticky memory-timeout flag.

Function
REQ-013 SHALL: memop = MemRead | MemWrite; MemRead and MemWrite both high is treated as a write.
REQ-014 SHALL: FSM states are IDLE and WAIT; reset state is IDLE.
REQ-015 SHALL: dmem_req = !reset & memop & (state==IDLE | state==WAIT), combinational.
REQ-016 SHALL: dmem_we = MemWrite; dmem_addr = ALUResult[9:2]; dmem_wdata = writedata; ALUResult[1:0] is ignored.
REQ-017 SHALL: stall = !reset & memop & !dmem_ack & !timeout_hit, combinational.
REQ-018 SHALL: IDLE with memop and no dmem_ack goes to WAIT; any dmem_ack or timeout_hit goes to IDLE.
REQ-019 SHALL: when ack arrives in the same cycle as the request, the access completes with zero stall cycles.
REQ-020 SHALL: when stall=0, on each rising edge MEM/WB loads RegWrite, MemtoReg, ALUResult and writeReg, and loads ReadDataOut from dmem_rdata (0 when !MemRead); latency is 1 cycle.
REQ-021 SHALL: when stall=1, MEM/WB loads a bubble: RegWriteOut=0, MemtoRegOut=0, all other fields 0.
REQ-022 SHALL: PCSrc = BranchTaken & !stall; PCBranchTarget = BranchTarget, combinational.
REQ-023 SHALL: a branch held under stall redirects in the cycle the stall releases.
REQ-024 SHALL: dmem_ack seen outside a memop is ignored and causes no state change.

Reset
REQ-025 SHALL: on reset, state=IDLE, all MEM/WB outputs are 0, the timeout counter is 0 and mem_err is 0.
REQ-026 SHALL: reset asserted mid-WAIT aborts the access; dmem_req and stall are 0 during the reset cycle.

Configuration
REQ-027 SHALL: MEM_TIMEOUT_EN defined: a 4-bit counter clears in IDLE and increments each WAIT cycle without ack.
REQ-028 SHALL: with MEM_TIMEOUT_EN, timeout_hit = (state==WAIT) & (count==15) & !dmem_ack.
REQ-029 SHALL: on timeout_hit, the stall releases, MEM/WB loads the instruction with ReadDataOut=32'h0, and mem_err sets until reset.
REQ-030 SHALL: with MEM_TIMEOUT_EN undefined, timeout_hit=0, WAIT persists indefinitely and mem_err is tied to 0.

Verification
REQ-031 SHALL: ALU op, ALUResult=32'h1234, writeReg=5, RegWrite=1 -> next edge RegWriteOut=1, ALUResultOut=32'h1234, stall never high.
REQ-032 SHALL: load with ALUResult=32'h40 and ack same cycle with rdata=32'hCAFEF00D -> dmem_addr=8'h10, stall=0, next edge ReadDataOut=32'hCAFEF00D.
REQ-033 SHALL: store with ack after 3 cycles -> stall high for 3 cycles, dmem_we=1, three bubbles (RegWriteOut=0), then release.
REQ-034 SHALL: BranchTaken=1, BranchTarget=8'h2A during a 2-cycle stall -> PCSrc=0 for 2 cycles, then PCSrc=1 with PCBranchTarget=8'h2A.
REQ-035 SHALL: reset asserted in the 2nd WAIT cycle -> next cycle state=IDLE, all outputs 0, dmem_req=0.
REQ-036 SHALL: with MEM_TIMEOUT_EN, a load never acked -> stall releases after 16 stalled cycles, mem_err=1, ReadDataOut=0.
